// File: rtl/bram_buf_pkg.sv
// Shared layout of the 128-word frame buffer, common to the writer and the reader.
// Holds the word bit-fields and the default geometry.
package bram_buf_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int RD_LAT_DEF = 2;
  localparam int DATA_W     = 8;
  localparam int DATA_LSB   = 0;
  localparam int EOF_BIT    = 8;
  localparam int WORD_W     = 9;

  typedef struct packed {
    logic              eof;
    logic [DATA_W-1:0] data;
  } buf_word_t;

  function automatic buf_word_t unpack_word(input logic [WORD_W-1:0] w);
    buf_word_t r;
    r.eof  = w[EOF_BIT];
    r.data = w[DATA_LSB +: DATA_W];
    return r;
  endfunction
endpackage

// File: rtl/skid_fifo.sv
// Small register-based FIFO that absorbs buffer reads already in flight when the consumer stalls.
// Depth need not be a power of two.
module skid_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_idx_reg;
  logic [PW-1:0]    rd_idx_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(DEPTH - 1)) ? '0 : i + PW'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign dout    = mem_reg[rd_idx_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_idx_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_idx_reg <= next_idx(wr_idx_reg);
      if (do_pop)  rd_idx_reg <= next_idx(rd_idx_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/bram128_reader.sv
// Reader side of the 128-word frame buffer: issues credited reads, retimes them through a
// skid FIFO and streams bytes out with valid/ready, counting frames and flagging overflow.
module bram128_reader
  import bram_buf_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W-1:0] addrb,
  input  logic [WORD_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic              ovf_err
);
  localparam int SCW = $clog2(SKID_DEPTH + 1);
  localparam int CW  = $clog2(SKID_DEPTH + RD_LAT + 1) + 1;

  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   level;
  logic [RD_LAT-1:0] stage_reg;
  logic              run_reg;
  logic              ovf_reg;
  logic [15:0]       frame_cnt_reg;
  logic              buf_empty;
  logic              issue;
  logic              push;
  logic              pop;
  logic              skid_empty;
  logic [SCW-1:0]    skid_count;
  logic [CW-1:0]     credit_used;
  logic [WORD_W-1:0] skid_head;
  buf_word_t         head_word;

  assign level     = wr_ptr - rd_ptr_reg;
  assign buf_empty = (level == '0);

  // Every read in the pipe already owns a skid slot, so counting them keeps the FIFO from overflowing.
  always_comb begin
    credit_used = CW'(skid_count);
    for (int i = 0; i < RD_LAT; i++) begin
      credit_used = credit_used + CW'(stage_reg[i]);
    end
  end

  assign issue = run_reg && !buf_empty && (credit_used < CW'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      run_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      stage_reg  <= '0;
    end else begin
      run_reg      <= 1'b1;
      stage_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
      if (issue) rd_ptr_reg <= rd_ptr_reg + (ADDR_W + 1)'(1);
      if (level > {1'b1, {ADDR_W{1'b0}}}) ovf_reg <= 1'b1;
    end
  end

  assign push = stage_reg[RD_LAT-1];
  assign pop  = !skid_empty && m_ready;

  skid_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (doutb),
    .dout  (skid_head),
    .count (skid_count),
    .empty (skid_empty)
  );

  assign head_word = unpack_word(skid_head);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
    end else if (pop && head_word.eof) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  // Outputs are masked while the skid is empty so stale entries never leak, including in reset.
  assign m_valid   = !skid_empty;
  assign m_data    = skid_empty ? '0 : head_word.data;
  assign m_last    = !skid_empty && head_word.eof;
  assign addrb     = rd_ptr_reg[ADDR_W-1:0];
  assign rd_ptr    = rd_ptr_reg;
  assign frame_cnt = frame_cnt_reg;
  assign ovf_err   = ovf_reg;
endmodule
